stopwatch_ctrl: RTL and testbench
=================================

Name: stopwatch_ctrl

Overview:
Control FSM and BCD time datapath for the stopwatch. Consumes the single-cycle tick enables from the clock divider (1 Hz, 2 Hz, 100 Hz, blink) and debounces the raw pause/reset buttons on the 100 Hz tick. Sequences run, pause and adjust modes, maintains MM:SS in BCD, and produces per-field blank flags for the seven-segment display driver.
All logic runs on sys_clk; ticks are enables, never clocks.

Parameters:
DEBOUNCE_TICKS, 3, consecutive fast_tick samples a button must differ from its stable value before the stable value flips (1..15)

Ports:
sys_clk  in  1  system clock (100 MHz)
rst  in  1  asynchronous, active-high reset
onehz_tick  in  1  one-cycle pulse, 1 Hz
twohz_tick  in  1  one-cycle pulse, 2 Hz
fast_tick  in  1  one-cycle pulse, 100 Hz, debounce sample strobe
blink_tick  in  1  one-cycle pulse, blink-phase toggle strobe
pause_btn  in  1  raw asynchronous button
reset_btn  in  1  raw asynchronous button
adj_sw  in  1  adjust-mode switch (level, synchronised internally)
sel_sw  in  1  adjust select: 0 = minutes, 1 = seconds (synchronised internally)
min_tens  out  3  minutes tens digit, 0..5
min_ones  out  4  minutes ones digit, 0..9
sec_tens  out  3  seconds tens digit, 0..5
sec_ones  out  4  seconds ones digit, 0..9
blank_min  out  1  1 = display blanks minute digits
blank_sec  out  1  1 = display blanks second digits
state  out  2  00 IDLE, 01 RUN, 10 PAUSED, 11 ADJUST

Behaviour:
- Reset (async assert, sync release): all digits 0, state IDLE, blank flags 0, blink_phase 0, debounce counters 0, stable button values 0, synchronisers 0.
- All four inputs pause_btn, reset_btn, adj_sw, sel_sw pass through 2-flop synchronisers: 2 cycles latency.
- Debounce, per button: on each fast_tick, if synced sample != stable, cnt++; else cnt = 0. When cnt would reach DEBOUNCE_TICKS, stable flips and cnt = 0. Between ticks, cnt holds.
- pause_evt: one-cycle pulse on a pause stable 0->1 transition. clr: the reset stable level.
- FSM, evaluated each cycle with this priority:
  1. adj_sw = 1 and state != ADJUST -> ADJUST.
  2. ADJUST and adj_sw = 0 -> PAUSED.
  3. clr = 1 and state in {RUN, PAUSED} -> IDLE.
  4. pause_evt: IDLE -> RUN, RUN -> PAUSED, PAUSED -> RUN. Ignored in ADJUST.
- Datapath actions always use the current registered state, not next state.
- clr = 1 forces all digits to 0 in every state, including ADJUST. Clear beats any tick in the same cycle.
- RUN, onehz_tick: sec_ones++.
  - 9 -> 0 carries into sec_tens; sec_tens 5 -> 0 carries into min_ones.
  - min_ones 9 -> 0 carries into min_tens.
  - 59:59 -> 00:00 wraps with no overflow flag.
- ADJUST, twohz_tick: increment the selected field (sel_sw = 0 minutes, 1 seconds) as a 00..59 BCD counter. 59 -> 00 with no carry into the other field; the unselected field holds.
- IDLE and PAUSED: digits hold.
- The RUN -> PAUSED cycle that carries a pause_evt still applies a coincident onehz_tick.
- Blink:
  - In ADJUST, blink_phase toggles on each blink_tick; blank_min = blink_phase & ~sel_sw; blank_sec = blink_phase & sel_sw.
  - Outside ADJUST, blink_phase is forced to 0 and both blank flags are 0.
  - Leaving ADJUST clears blink_phase in the same cycle.
- Outputs are registered; digit update is visible on the cycle after the tick.
- Reset asserted mid-count or mid-debounce returns everything to reset values immediately.

Test Plan:
- Run from reset: pulse pause_btn (stable 3 fast_ticks), apply 61 onehz_ticks -> state 01, display 01:01.
- Wrap: preload 59:59 via ADJUST, exit to PAUSED, resume RUN, one onehz_tick -> 00:00, state 01.
- Pause/resume: in RUN at 00:05, pause press -> state 10; 10 onehz_ticks -> still 00:05; press again -> state 01; one tick -> 00:06.
- Debounce: pause_btn bounces 1,0,1 across 3 fast_ticks then holds 1 -> exactly one pause_evt; a 2-fast_tick glitch -> no state change.
- Adjust: adj_sw = 1, sel_sw = 0, 61 twohz_ticks from 00:00 -> 01:00; seconds unchanged. Blink_ticks toggle blank_min while blank_sec stays 0. adj_sw = 0 -> state 10, blanks 0.
- Clear priority: in RUN at 00:42, reset_btn held with a coincident onehz_tick on the stable cycle -> 00:00, state 00. The same press in ADJUST -> 00:00, state 11.

Source files
------------

// File: rtl/stopwatch_ctrl_if.sv
// stopwatch_ctrl_if: groups the stopwatch controller's tick, button and display signals.
//   master : tick/button/switch source, display sink (clock divider / board / bench side)
//   slave  : the controller itself
//   ticks    : onehz_tick, twohz_tick, fast_tick, blink_tick (one-cycle enables)
//   buttons  : pause_btn, reset_btn (raw), adj_sw, sel_sw (levels)
//   display  : min_tens, min_ones, sec_tens, sec_ones (BCD), blank_min, blank_sec, state
interface stopwatch_ctrl_if;
   logic       onehz_tick;
   logic       twohz_tick;
   logic       fast_tick;
   logic       blink_tick;
   logic       pause_btn;
   logic       reset_btn;
   logic       adj_sw;
   logic       sel_sw;
   logic [2:0] min_tens;
   logic [3:0] min_ones;
   logic [2:0] sec_tens;
   logic [3:0] sec_ones;
   logic       blank_min;
   logic       blank_sec;
   logic [1:0] state;

   modport master (
      output onehz_tick, twohz_tick, fast_tick, blink_tick,
      output pause_btn, reset_btn, adj_sw, sel_sw,
      input  min_tens, min_ones, sec_tens, sec_ones,
      input  blank_min, blank_sec, state
   );

   modport slave (
      input  onehz_tick, twohz_tick, fast_tick, blink_tick,
      input  pause_btn, reset_btn, adj_sw, sel_sw,
      output min_tens, min_ones, sec_tens, sec_ones,
      output blank_min, blank_sec, state
   );
endinterface

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: run/pause/adjust sequencer and MM:SS BCD datapath.
//   sys_clk : system clock, all state on this clock
//   rst     : asynchronous, active-high reset
//   bus     : stopwatch_ctrl_if.slave (ticks, raw buttons, switches, display outputs)
// sw_debounce: one button debouncer, sampled on a tick enable.
//   smp_tick : sample strobe; din : synchronised button; dout : stable level

module sw_debounce #(
   parameter int DEBOUNCE_TICKS = 3
) (
   input  logic sys_clk,
   input  logic rst,
   input  logic smp_tick,
   input  logic din,
   output logic dout
);
   logic [3:0] cnt;

   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         cnt  <= '0;
         dout <= 1'b0;
      end else if (smp_tick) begin
         if (din != dout) begin
            // flip on the sample that would bring the count to DEBOUNCE_TICKS
            if (cnt == 4'(DEBOUNCE_TICKS - 1)) begin
               dout <= ~dout;
               cnt  <= '0;
            end else begin
               cnt <= cnt + 4'd1;
            end
         end else begin
            cnt <= '0;
         end
      end
   end
endmodule

module stopwatch_ctrl #(
   parameter int DEBOUNCE_TICKS = 3
) (
   input  logic             sys_clk,
   input  logic             rst,
   stopwatch_ctrl_if.slave  bus
);
   localparam int NUM_BTN = 2;  // 0 = pause, 1 = reset

   typedef enum logic [1:0] {
      S_IDLE   = 2'b00,
      S_RUN    = 2'b01,
      S_PAUSED = 2'b10,
      S_ADJUST = 2'b11
   } state_t;

   // {sel_sw, adj_sw, reset_btn, pause_btn}
   logic [3:0]         sync1, sync2;
   logic [NUM_BTN-1:0] btn_stable;
   logic               pause_q;
   logic               pause_evt, clr, adj, sel;
   state_t             st, st_nxt;
   logic [6:0]         min_f, sec_f;  // {tens[2:0], ones[3:0]}
   logic               blink_phase, ph_nxt;
   logic               blank_min_q, blank_sec_q;

   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= {bus.sel_sw, bus.adj_sw, bus.reset_btn, bus.pause_btn};
         sync2 <= sync1;
      end
   end

   genvar g;
   generate
      for (g = 0; g < NUM_BTN; g++) begin : g_db
         sw_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_db (
            .sys_clk  (sys_clk),
            .rst      (rst),
            .smp_tick (bus.fast_tick),
            .din      (sync2[g]),
            .dout     (btn_stable[g])
         );
      end
   endgenerate

   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) pause_q <= 1'b0;
      else     pause_q <= btn_stable[0];
   end

   assign pause_evt = btn_stable[0] & ~pause_q;
   assign clr       = btn_stable[1];
   assign adj       = sync2[2];
   assign sel       = sync2[3];

   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) st <= S_IDLE;
      else     st <= st_nxt;
   end

   always_comb begin
      st_nxt = st;
      if (adj && st != S_ADJUST)
         st_nxt = S_ADJUST;
      else if (st == S_ADJUST && !adj)
         st_nxt = S_PAUSED;
      else if (clr && (st == S_RUN || st == S_PAUSED))
         st_nxt = S_IDLE;
      else if (pause_evt) begin
         case (st)
            S_IDLE:   st_nxt = S_RUN;
            S_RUN:    st_nxt = S_PAUSED;
            S_PAUSED: st_nxt = S_RUN;
            default:  st_nxt = st;
         endcase
      end
   end

   // 00..59 BCD increment, wrapping to 00
   function automatic logic [6:0] bcd60_inc(input logic [6:0] v);
      if (v[3:0] != 4'd9)      return {v[6:4], v[3:0] + 4'd1};
      else if (v[6:4] != 3'd5) return {v[6:4] + 3'd1, 4'd0};
      else                     return 7'd0;
   endfunction

   // Datapath keys off the registered state; a RUN->PAUSED cycle still counts.
   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         min_f <= '0;
         sec_f <= '0;
      end else if (clr) begin
         min_f <= '0;
         sec_f <= '0;
      end else begin
         case (st)
            S_RUN: if (bus.onehz_tick) begin
               sec_f <= bcd60_inc(sec_f);
               if (sec_f == 7'h59) min_f <= bcd60_inc(min_f);
            end
            S_ADJUST: if (bus.twohz_tick) begin
               if (sel) sec_f <= bcd60_inc(sec_f);
               else     min_f <= bcd60_inc(min_f);
            end
            default: ;
         endcase
      end
   end

   // Phase only runs while staying in ADJUST; leaving clears it the same cycle.
   assign ph_nxt = (st == S_ADJUST && st_nxt == S_ADJUST) ?
                   (blink_phase ^ bus.blink_tick) : 1'b0;

   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         blink_phase <= 1'b0;
         blank_min_q <= 1'b0;
         blank_sec_q <= 1'b0;
      end else begin
         blink_phase <= ph_nxt;
         blank_min_q <= ph_nxt & ~sel;
         blank_sec_q <= ph_nxt & sel;
      end
   end

   assign bus.min_tens  = min_f[6:4];
   assign bus.min_ones  = min_f[3:0];
   assign bus.sec_tens  = sec_f[6:4];
   assign bus.sec_ones  = sec_f[3:0];
   assign bus.blank_min = blank_min_q;
   assign bus.blank_sec = blank_sec_q;
   assign bus.state     = st;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
module tb_stopwatch_ctrl;
   logic sys_clk = 1'b0;
   logic rst     = 1'b1;
   int   n_chk   = 0;
   int   n_err   = 0;

   stopwatch_ctrl_if sw_if();

   stopwatch_ctrl #(.DEBOUNCE_TICKS(3)) dut (
      .sys_clk (sys_clk),
      .rst     (rst),
      .bus     (sw_if)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
      end
   endtask

   // MM:SS packed as four hex nibbles, e.g. 01:01 -> 16'h0101
   function automatic logic [15:0] disp();
      return {1'b0, sw_if.min_tens, sw_if.min_ones, 1'b0, sw_if.sec_tens, sw_if.sec_ones};
   endfunction

   task automatic cyc(input int n);
      repeat (n) @(negedge sys_clk);
   endtask

   // 0 onehz, 1 twohz, 2 fast, 3 blink
   task automatic pulse(input int which, input int n);
      repeat (n) begin
         case (which)
            0: sw_if.onehz_tick = 1'b1;
            1: sw_if.twohz_tick = 1'b1;
            2: sw_if.fast_tick  = 1'b1;
            default: sw_if.blink_tick = 1'b1;
         endcase
         cyc(1);
         sw_if.onehz_tick = 1'b0;
         sw_if.twohz_tick = 1'b0;
         sw_if.fast_tick  = 1'b0;
         sw_if.blink_tick = 1'b0;
         cyc(1);
      end
   endtask

   task automatic set_pause(input logic v);
      sw_if.pause_btn = v;
      cyc(3);
      pulse(2, 3);
      cyc(3);
   endtask

   task automatic press_pause();
      set_pause(1'b1);
      set_pause(1'b0);
   endtask

   task automatic set_reset(input logic v);
      sw_if.reset_btn = v;
      cyc(3);
      pulse(2, 3);
      cyc(3);
   endtask

   // reset press whose first stable cycle carries a onehz (0) or twohz (1) tick
   task automatic clr_with_tick(input int which);
      sw_if.reset_btn = 1'b1;
      cyc(3);
      pulse(2, 2);
      sw_if.fast_tick = 1'b1;
      cyc(1);
      sw_if.fast_tick = 1'b0;
      if (which == 0) sw_if.onehz_tick = 1'b1;
      else            sw_if.twohz_tick = 1'b1;
      cyc(1);
      sw_if.onehz_tick = 1'b0;
      sw_if.twohz_tick = 1'b0;
   endtask

   initial begin
      sw_if.onehz_tick = 1'b0;
      sw_if.twohz_tick = 1'b0;
      sw_if.fast_tick  = 1'b0;
      sw_if.blink_tick = 1'b0;
      sw_if.pause_btn  = 1'b0;
      sw_if.reset_btn  = 1'b0;
      sw_if.adj_sw     = 1'b0;
      sw_if.sel_sw     = 1'b0;
      cyc(3);
      rst = 1'b0;
      cyc(2);
      chk("rst_disp",  disp(), 16'h0000);
      chk("rst_state", 16'(sw_if.state), 16'h0);
      chk("rst_blank", 16'({sw_if.blank_min, sw_if.blank_sec}), 16'h0);

      // run from reset
      press_pause();
      chk("run_state", 16'(sw_if.state), 16'h1);
      pulse(0, 61);
      chk("run_61", disp(), 16'h0101);

      // clear back to idle, then pause/resume
      set_reset(1'b1);
      chk("clr_disp",  disp(), 16'h0000);
      chk("clr_state", 16'(sw_if.state), 16'h0);
      set_reset(1'b0);
      press_pause();
      pulse(0, 5);
      chk("run_5", disp(), 16'h0005);
      press_pause();
      chk("pause_state", 16'(sw_if.state), 16'h2);
      pulse(0, 10);
      chk("pause_hold", disp(), 16'h0005);
      press_pause();
      chk("resume_state", 16'(sw_if.state), 16'h1);
      pulse(0, 1);
      chk("resume_tick", disp(), 16'h0006);

      // bouncing press 1,0,1 then held -> single event RUN->PAUSED
      sw_if.pause_btn = 1'b1; cyc(3); pulse(2, 1);
      sw_if.pause_btn = 1'b0; cyc(3); pulse(2, 1);
      sw_if.pause_btn = 1'b1; cyc(3); pulse(2, 1);
      chk("bounce_pre", 16'(sw_if.state), 16'h1);
      pulse(2, 2);
      cyc(3);
      chk("bounce_one", 16'(sw_if.state), 16'h2);
      set_pause(1'b0);
      // 2-sample glitch
      sw_if.pause_btn = 1'b1; cyc(3); pulse(2, 2);
      sw_if.pause_btn = 1'b0; cyc(3); pulse(2, 2);
      cyc(3);
      chk("glitch", 16'(sw_if.state), 16'h2);

      // adjust minutes from 00:00
      set_reset(1'b1);
      set_reset(1'b0);
      chk("pre_adj", disp(), 16'h0000);
      sw_if.adj_sw = 1'b1;
      sw_if.sel_sw = 1'b0;
      cyc(4);
      chk("adj_state", 16'(sw_if.state), 16'h3);
      pulse(1, 61);
      chk("adj_61", disp(), 16'h0100);
      pulse(3, 1);
      chk("blink1", 16'({sw_if.blank_min, sw_if.blank_sec}), 16'h2);
      pulse(3, 1);
      chk("blink2", 16'({sw_if.blank_min, sw_if.blank_sec}), 16'h0);
      pulse(3, 1);
      chk("blink3", 16'({sw_if.blank_min, sw_if.blank_sec}), 16'h2);
      sw_if.sel_sw = 1'b1;
      cyc(4);
      chk("blink_sel", 16'({sw_if.blank_min, sw_if.blank_sec}), 16'h1);
      sw_if.adj_sw = 1'b0;
      cyc(4);
      chk("adj_exit", 16'(sw_if.state), 16'h2);
      chk("adj_exit_blank", 16'({sw_if.blank_min, sw_if.blank_sec}), 16'h0);

      // wrap: preload 59:59
      sw_if.adj_sw = 1'b1;
      sw_if.sel_sw = 1'b0;
      cyc(4);
      pulse(1, 58);
      sw_if.sel_sw = 1'b1;
      cyc(4);
      pulse(1, 59);
      chk("preload", disp(), 16'h5959);
      sw_if.adj_sw = 1'b0;
      cyc(4);
      press_pause();
      chk("wrap_run", 16'(sw_if.state), 16'h1);
      pulse(0, 1);
      chk("wrap", disp(), 16'h0000);

      // clear beats coincident onehz in RUN
      pulse(0, 42);
      chk("run_42", disp(), 16'h0042);
      clr_with_tick(0);
      chk("clr_run_disp",  disp(), 16'h0000);
      chk("clr_run_state", 16'(sw_if.state), 16'h0);
      set_reset(1'b0);

      // clear in ADJUST keeps state
      sw_if.adj_sw = 1'b1;
      sw_if.sel_sw = 1'b0;
      cyc(4);
      pulse(1, 3);
      chk("adj_3", disp(), 16'h0300);
      clr_with_tick(1);
      chk("clr_adj_disp",  disp(), 16'h0000);
      chk("clr_adj_state", 16'(sw_if.state), 16'h3);
      set_reset(1'b0);
      sw_if.adj_sw = 1'b0;
      cyc(4);

      // async reset mid-count / mid-debounce
      press_pause();
      pulse(0, 7);
      chk("run_7", disp(), 16'h0007);
      sw_if.pause_btn = 1'b1;
      cyc(3);
      pulse(2, 2);
      rst = 1'b1;
      cyc(1);
      chk("mid_rst_disp",  disp(), 16'h0000);
      chk("mid_rst_state", 16'(sw_if.state), 16'h0);
      rst = 1'b0;
      cyc(3);
      pulse(2, 2);
      cyc(3);
      chk("mid_rst_cnt", 16'(sw_if.state), 16'h0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
